// File: rtl/mmm_r2_engine_if.sv
// Handshake and operand bus for mmm_r2_engine.
// The requester (master) drives start and the operands; the engine (slave)
// returns busy, done, err and the Montgomery product.
interface mmm_r2_engine_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] N;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH:0]   result;

    modport master (
        output start, A, B, N,
        input  busy, done, err, result
    );

    modport slave (
        input  start, A, B, N,
        output busy, done, err, result
    );
endinterface

// File: rtl/mmm_r2_engine.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod N.
// One multiplier bit is consumed per clock in ITER.
// Optional feature macro: MMM_FINAL_SUB_EN adds a one-cycle SUB state that
// brings the result into [0, N); without it the result lies in [0, 2N).
// Reset (rst) is synchronous and active-low.
module mmm_r2_engine #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    mmm_r2_engine_if.slave     bus
);
    // Accumulator is two bits wider than the operands: S < 2N keeps
    // S + B + N below 2^(WIDTH+2) for every legal input.
    localparam int SW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SUB,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, n_q;
    logic [CW-1:0]    cnt_q;
    logic [SW-1:0]    s_q;
    logic [WIDTH:0]   result_q;

    logic             last_iter;
    logic [SW-1:0]    t_sum;
    logic [SW-1:0]    u_sum;
    logic [SW-1:0]    iter_s;
    logic [SW-1:0]    sub_s;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // One Montgomery step and the optional final subtraction.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        t_sum  = s_q + (a_q[cnt_q] ? {2'b00, b_q} : '0);
        u_sum  = t_sum + (t_sum[0] ? {2'b00, n_q} : '0);
        iter_s = u_sum >> 1;
        sub_s  = (s_q >= {2'b00, n_q}) ? (s_q - {2'b00, n_q}) : s_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it is ignored while busy or done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = bus.N[0] ? ITER : DONE;
                end
            end
            ITER: begin
                if (last_iter) begin
`ifdef MMM_FINAL_SUB_EN
                    state_d = SUB;
`else
                    state_d = DONE;
`endif
                end
            end
            SUB:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: operand capture, accumulator, bit counter, held result.
    always_ff @(posedge clk) begin
        // NOTE: the operand registers are ordinary flops, not a memory, so they are cleared with the rest.
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        n_q   <= bus.N;
                        s_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                ITER: begin
                    s_q   <= iter_s;
                    cnt_q <= cnt_q + CW'(1);
                end
                SUB: begin
                    s_q <= sub_s;
                end
                DONE: begin
                    result_q <= s_q[WIDTH:0];
                end
                default: begin
                    s_q <= s_q;
                end
            endcase
        end
    end

    // Outputs decoded from state; result shows S live in DONE and the held copy elsewhere.
    always_comb begin
        bus.busy   = (state_q == ITER) || (state_q == SUB);
        bus.done   = (state_q == DONE);
        bus.err    = (state_q == DONE) && !n_q[0];
        bus.result = (state_q == DONE) ? s_q[WIDTH:0] : result_q;
    end
endmodule
